// File: rtl/dadda_product_accumulator_if.sv
// Product-in / group-result-out handshake bundle for dadda_product_accumulator.
interface dadda_product_accumulator_if #(
  parameter int PROD_W    = 8,
  parameter int ACC_W     = 16,
  parameter int MAX_TERMS = 16
);
  localparam int CW = $clog2(MAX_TERMS + 1);

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] product;
  logic              in_last;
  logic              clear;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic [CW-1:0]     term_count;
  logic              overflow;

  modport slave (
    input  in_valid, product, in_last, clear, out_ready,
    output in_ready, out_valid, acc_out, term_count, overflow
  );

  modport master (
    output in_valid, product, in_last, clear, out_ready,
    input  in_ready, out_valid, acc_out, term_count, overflow
  );
endinterface

// File: rtl/dadda_product_accumulator.sv
// Sums a stream of multiplier products into groups; each closed group is held
// behind a valid/ready handshake until the consumer takes it.
module dadda_product_accumulator #(
  parameter int PROD_W    = 8,
  parameter int ACC_W     = 16,
  parameter int MAX_TERMS = 16
) (
  input  logic clock,
  input  logic reset,
  dadda_product_accumulator_if.slave bus
);
  localparam int CW = $clog2(MAX_TERMS + 1);
  localparam int SW = ACC_W + 1;

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc_q;
  logic [CW-1:0]    count_q;
  logic             ovf_q;

  logic [ACC_W-1:0] base_acc;
  logic [CW-1:0]    base_cnt;
  logic             base_ovf;
  logic [SW-1:0]    sum;
  logic [CW-1:0]    cnt_next;
  logic             close;

  // A clear coinciding with a beat restarts the group from that beat.
  always_comb begin
    base_acc = bus.clear ? '0 : acc_q;
    base_cnt = bus.clear ? '0 : count_q;
    base_ovf = bus.clear ? 1'b0 : ovf_q;
    sum      = {1'b0, base_acc} + SW'(bus.product);
    cnt_next = base_cnt + 1'b1;
    close    = bus.in_last || (cnt_next == CW'(MAX_TERMS));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ACCUM;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (bus.in_valid) begin
            acc_q   <= sum[ACC_W-1:0];
            count_q <= cnt_next;
            ovf_q   <= base_ovf | sum[ACC_W];
            if (close) state <= HOLD;
          end else if (bus.clear) begin
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state   <= ACCUM;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.in_ready   = (state == ACCUM);
  assign bus.out_valid  = (state == HOLD);
  assign bus.acc_out    = acc_q;
  assign bus.term_count = count_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_dadda_product_accumulator.sv
// Directed bench for dadda_product_accumulator: a 16-bit instance and a
// 10-bit instance (wraparound/overflow) sharing clock and reset.
module tb_dadda_product_accumulator;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int passes = 0;

  always #5 clock = ~clock;

  dadda_product_accumulator_if #(.PROD_W(8), .ACC_W(16), .MAX_TERMS(16)) b ();
  dadda_product_accumulator_if #(.PROD_W(8), .ACC_W(10), .MAX_TERMS(16)) b10 ();

  dadda_product_accumulator #(.PROD_W(8), .ACC_W(16), .MAX_TERMS(16)) dut (
    .clock(clock), .reset(reset), .bus(b.slave));
  dadda_product_accumulator #(.PROD_W(8), .ACC_W(10), .MAX_TERMS(16)) dut10 (
    .clock(clock), .reset(reset), .bus(b10.slave));

  // Inputs change just after the falling edge; outputs are sampled there too.
  task automatic beat(input int p, input bit last, input bit clr);
    b.in_valid = 1'b1; b.product = 8'(p); b.in_last = last; b.clear = clr;
    @(negedge clock);
    b.in_valid = 1'b0; b.in_last = 1'b0; b.clear = 1'b0;
  endtask

  task automatic beat10(input int p, input bit last);
    b10.in_valid = 1'b1; b10.product = 8'(p); b10.in_last = last;
    @(negedge clock);
    b10.in_valid = 1'b0; b10.in_last = 1'b0;
  endtask

  task automatic take;
    b.out_ready = 1'b1;
    @(negedge clock);
    b.out_ready = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (b.out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", b.out_valid); else passes++;
    checks++; if (b.in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", b.in_ready); else passes++;
    checks++; if (b.acc_out !== 16'd0 || b.term_count !== 5'd0 || b.overflow !== 1'b0)
      $display("FAIL reset_regs got acc=%0d cnt=%0d ovf=%0b want 0/0/0", b.acc_out, b.term_count, b.overflow); else passes++;
  endtask

  task automatic test_basic_group;
    beat(225, 0, 0); beat(10, 0, 0);
    checks++; if (b.out_valid !== 1'b0 || b.acc_out !== 16'd235) $display("FAIL basic_partial got ov=%0b acc=%0d want 0/235", b.out_valid, b.acc_out); else passes++;
    beat(5, 1, 0);
    checks++; if (b.out_valid !== 1'b1 || b.in_ready !== 1'b0) $display("FAIL basic_latency got ov=%0b ir=%0b want 1/0", b.out_valid, b.in_ready); else passes++;
    checks++; if (b.acc_out !== 16'd240 || b.term_count !== 5'd3 || b.overflow !== 1'b0)
      $display("FAIL basic_result got acc=%0d cnt=%0d ovf=%0b want 240/3/0", b.acc_out, b.term_count, b.overflow); else passes++;
    take();
    checks++; if (b.in_ready !== 1'b1 || b.out_valid !== 1'b0 || b.acc_out !== 16'd0 || b.term_count !== 5'd0)
      $display("FAIL basic_handoff got ir=%0b ov=%0b acc=%0d cnt=%0d want 1/0/0/0", b.in_ready, b.out_valid, b.acc_out, b.term_count); else passes++;
  endtask

  task automatic test_auto_close;
    for (int i = 0; i < 15; i++) beat(225, 0, 0);
    checks++; if (b.in_ready !== 1'b1 || b.term_count !== 5'd15 || b.acc_out !== 16'd3375)
      $display("FAIL auto_15 got ir=%0b cnt=%0d acc=%0d want 1/15/3375", b.in_ready, b.term_count, b.acc_out); else passes++;
    beat(225, 0, 0);
    checks++; if (b.out_valid !== 1'b1 || b.acc_out !== 16'd3600 || b.term_count !== 5'd16)
      $display("FAIL auto_16 got ov=%0b acc=%0d cnt=%0d want 1/3600/16", b.out_valid, b.acc_out, b.term_count); else passes++;
    take();
  endtask

  task automatic test_backpressure;
    int bad = 0;
    beat(9, 1, 0);
    b.in_valid = 1'b1; b.product = 8'd50;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (b.out_valid !== 1'b1 || b.in_ready !== 1'b0 || b.acc_out !== 16'd9 || b.term_count !== 5'd1) bad++;
    end
    checks++; if (bad != 0) $display("FAIL hold_stable got %0d bad cycles want 0", bad); else passes++;
    b.out_ready = 1'b1;
    @(negedge clock);
    b.out_ready = 1'b0; b.in_valid = 1'b0;
    checks++; if (b.in_ready !== 1'b1 || b.acc_out !== 16'd0 || b.term_count !== 5'd0)
      $display("FAIL hold_handoff got ir=%0b acc=%0d cnt=%0d want 1/0/0", b.in_ready, b.acc_out, b.term_count); else passes++;
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 5; i++) beat10(225, i == 4);
    checks++; if (b10.out_valid !== 1'b1 || b10.acc_out !== 10'd101 || b10.overflow !== 1'b1 || b10.term_count !== 5'd5)
      $display("FAIL ovf_wrap got ov=%0b acc=%0d ovf=%0b cnt=%0d want 1/101/1/5", b10.out_valid, b10.acc_out, b10.overflow, b10.term_count); else passes++;
    b10.out_ready = 1'b1; @(negedge clock); b10.out_ready = 1'b0;
    beat10(4, 1);
    checks++; if (b10.acc_out !== 10'd4 || b10.overflow !== 1'b0 || b10.term_count !== 5'd1)
      $display("FAIL ovf_cleared got acc=%0d ovf=%0b cnt=%0d want 4/0/1", b10.acc_out, b10.overflow, b10.term_count); else passes++;
    b10.out_ready = 1'b1; @(negedge clock); b10.out_ready = 1'b0;
  endtask

  task automatic test_clear;
    beat(100, 0, 0);
    beat(7, 1, 1);
    checks++; if (b.out_valid !== 1'b1 || b.acc_out !== 16'd7 || b.term_count !== 5'd1)
      $display("FAIL clear_with_beat got ov=%0b acc=%0d cnt=%0d want 1/7/1", b.out_valid, b.acc_out, b.term_count); else passes++;
    take();
    beat(30, 0, 0);
    b.clear = 1'b1; @(negedge clock); b.clear = 1'b0;
    checks++; if (b.acc_out !== 16'd0 || b.term_count !== 5'd0 || b.in_ready !== 1'b1)
      $display("FAIL clear_only got acc=%0d cnt=%0d ir=%0b want 0/0/1", b.acc_out, b.term_count, b.in_ready); else passes++;
    beat(12, 1, 0);
    b.clear = 1'b1; @(negedge clock); b.clear = 1'b0;
    checks++; if (b.out_valid !== 1'b1 || b.acc_out !== 16'd12 || b.term_count !== 5'd1)
      $display("FAIL clear_in_hold got ov=%0b acc=%0d cnt=%0d want 1/12/1", b.out_valid, b.acc_out, b.term_count); else passes++;
    take();
  endtask

  task automatic test_reset_mid;
    beat(40, 0, 0); beat(41, 0, 0);
    do_reset();
    checks++; if (b.out_valid !== 1'b0 || b.acc_out !== 16'd0 || b.term_count !== 5'd0)
      $display("FAIL reset_mid_group got ov=%0b acc=%0d cnt=%0d want 0/0/0", b.out_valid, b.acc_out, b.term_count); else passes++;
    beat(0, 0, 0); beat(0, 1, 0);
    checks++; if (b.out_valid !== 1'b1 || b.acc_out !== 16'd0 || b.term_count !== 5'd2)
      $display("FAIL zero_terms got ov=%0b acc=%0d cnt=%0d want 1/0/2", b.out_valid, b.acc_out, b.term_count); else passes++;
    do_reset();
    checks++; if (b.out_valid !== 1'b0 || b.in_ready !== 1'b1 || b.term_count !== 5'd0)
      $display("FAIL reset_mid_hold got ov=%0b ir=%0b cnt=%0d want 0/1/0", b.out_valid, b.in_ready, b.term_count); else passes++;
  endtask

  task automatic test_sweep;
    for (int a = 0; a < 16; a++) begin
      int ref_sum = 0;
      for (int bb = 0; bb < 16; bb++) begin
        ref_sum += a * bb;
        beat(a * bb, 0, 0);
      end
      checks++;
      if (b.out_valid !== 1'b1 || b.acc_out !== 16'(ref_sum) || b.term_count !== 5'd16 || b.overflow !== 1'b0)
        $display("FAIL sweep_a%0d got ov=%0b acc=%0d cnt=%0d ovf=%0b want 1/%0d/16/0",
                 a, b.out_valid, b.acc_out, b.term_count, b.overflow, ref_sum);
      else passes++;
      take();
    end
  endtask

  initial begin
    b.in_valid = 1'b0; b.product = '0; b.in_last = 1'b0; b.clear = 1'b0; b.out_ready = 1'b0;
    b10.in_valid = 1'b0; b10.product = '0; b10.in_last = 1'b0; b10.clear = 1'b0; b10.out_ready = 1'b0;
    @(negedge clock);
    test_reset();
    test_basic_group();
    test_auto_close();
    test_backpressure();
    test_overflow();
    test_clear();
    test_reset_mid();
    test_sweep();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
